// File: rtl/snax_tcdm_responder.sv
// Banked TCDM model answering SNAX accelerator request streams.
// Round-robin bank arbitration, strobed writes, one-cycle registered response.
package snax_tcdm_pkg;
  localparam int unsigned AddrWidth = 17;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic                   amo;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;
endpackage

module snax_tcdm_responder #(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned BankDepth = 64,
  parameter type tcdm_req_t = snax_tcdm_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_pkg::tcdm_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  tcdm_req_t   tcdm_req_i [NumPorts],
  output tcdm_rsp_t   tcdm_rsp_o [NumPorts],
  output logic [31:0] conflict_cnt_o
);
  localparam int unsigned PortW = $clog2(NumPorts);
  localparam int unsigned BankW = $clog2(NumBanks);
  localparam int unsigned RowW  = $clog2(BankDepth);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned CntW  = $clog2(NumPorts + 1);

  if (DataWidth != 64) begin : g_bad_dw
    $error("DataWidth must be 64");
  end
  if (AddrWidth < 3 + BankW + RowW) begin : g_bad_aw
    $error("AddrWidth too small for bank map");
  end

  logic [DataWidth-1:0] mem_q [NumBanks][BankDepth];
  logic [PortW-1:0]     rr_q [NumBanks];
  logic [BankW-1:0]     bank [NumPorts];
  logic [RowW-1:0]      row [NumPorts];
  logic [NumPorts-1:0]  gnt;
  logic [NumBanks-1:0]  bank_gnt;
  logic [PortW-1:0]     bank_port [NumBanks];
  logic [NumPorts-1:0]  p_valid_q;
  logic [DataWidth-1:0] p_data_q [NumPorts];
  logic [CntW-1:0]      n_conf;
  logic [32:0]          cnt_sum;
  logic [31:0]          cnt_q;
  logic                 unused_bits;
  int unsigned          arb_idx;
  logic [PortW-1:0]     arb_p;

  always_comb begin
    unused_bits = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      bank[p] = tcdm_req_i[p].q.addr[3 +: BankW];
      row[p]  = tcdm_req_i[p].q.addr[3 + BankW +: RowW];
      unused_bits ^= ^{tcdm_req_i[p].q.amo,
                       tcdm_req_i[p].q.user,
                       tcdm_req_i[p].q.addr};
    end
  end

  // Search upward from rr_q[b], wrapping; reset masks every grant.
  always_comb begin
    arb_idx  = 0;
    arb_p    = '0;
    bank_gnt = '0;
    gnt      = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_port[b] = '0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
        arb_idx = (32'(rr_q[b]) + k) % NumPorts;
        arb_p   = PortW'(arb_idx);
        if (rst_ni && !bank_gnt[b] &&
            tcdm_req_i[arb_p].q_valid &&
            bank[arb_p] == BankW'(b)) begin
          bank_gnt[b]  = 1'b1;
          bank_port[b] = arb_p;
          gnt[arb_p]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    n_conf = '0;
    for (int p = 0; p < NumPorts; p++) begin
      n_conf += CntW'(tcdm_req_i[p].q_valid && !gnt[p]);
    end
    cnt_sum = {1'b0, cnt_q} + 33'(n_conf);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) begin
        rr_q[b] <= '0;
        for (int r = 0; r < BankDepth; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (bank_gnt[b]) begin
          rr_q[b] <= (bank_port[b] == PortW'(NumPorts - 1)) ?
                     '0 : bank_port[b] + 1'b1;
          if (tcdm_req_i[bank_port[b]].q.write) begin
            for (int s = 0; s < StrbW; s++) begin
              if (tcdm_req_i[bank_port[b]].q.strb[s]) begin
                mem_q[b][row[bank_port[b]]][8*s +: 8] <=
                  tcdm_req_i[bank_port[b]].q.data[8*s +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_valid_q <= '0;
      for (int p = 0; p < NumPorts; p++) begin
        p_data_q[p] <= '0;
      end
    end else begin
      p_valid_q <= gnt;
      for (int p = 0; p < NumPorts; p++) begin
        p_data_q[p] <= (gnt[p] && !tcdm_req_i[p].q.write) ?
                       mem_q[bank[p]][row[p]] : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      tcdm_rsp_o[p].q_ready = gnt[p];
      tcdm_rsp_o[p].p_valid = p_valid_q[p];
      tcdm_rsp_o[p].p.data  = p_data_q[p];
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/snax_tcdm_responder.md
# snax_tcdm_responder

Multi-port, word-interleaved TCDM memory model that answers the `tcdm_req_t` request streams issued by SNAX accelerators such as the GEMM block. It arbitrates port-to-bank conflicts round-robin, executes reads and byte-strobed writes, and returns a registered response one cycle after grant. It sits on the accelerator's TCDM port array in block-level benches and in small standalone clusters.

## Interface
- `NumPorts`, 16, number of requestor ports.
- `DataWidth`, 64, word width in bits; must be 64.
- `AddrWidth`, 17, byte address width.
- `NumBanks`, 32, banks; power of two.
- `BankDepth`, 64, words per bank; power of two.
- `tcdm_req_t`, logic, request struct: `q_valid`, `q.addr[AddrWidth]`, `q.write`, `q.amo`, `q.data[DataWidth]`, `q.strb[DataWidth/8]`, `q.user`.
- `tcdm_rsp_t`, logic, response struct: `q_ready`, `p_valid`, `p.data[DataWidth]`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `tcdm_req_i`  in  NumPorts x tcdm_req_t  per-port requests.
- `tcdm_rsp_o`  out  NumPorts x tcdm_rsp_t  per-port grant and response.
- `conflict_cnt_o`  out  32  count of port-cycles lost to bank conflicts.

## Operation
- Address map: `addr[2:0]` ignored. Bank = `addr[3 +: log2(NumBanks)]`. Row = next `log2(BankDepth)` bits. Higher address bits are ignored, so addresses alias modulo `NumBanks*BankDepth*8` bytes (16 KiB at defaults).
- Storage: `NumBanks` x `BankDepth` x 64 bit; cleared to zero on reset.
- Arbitration, per bank:
  - The candidates are ports with `q_valid=1` targeting that bank.
  - Grant goes to the first candidate at index >= `rr_q[b]`, searching upward and wrapping.
  - On a grant, `rr_q[b] <= granted+1` (mod `NumPorts`). Without a grant, `rr_q[b]` holds.
  - `rr_q` resets to 0.
- `q_ready[p]` = 1 only when port p is granted. `q_ready` is 0 for ports with `q_valid=0`.
- Read grant: `rdata <= mem[bank][row]`, returned on the port next cycle.
- Write grant: each byte with `strb[k]=1` is written from `q.data`; other bytes are unchanged. A write with `strb=0` changes nothing and still produces a response.
- `q.amo` and `q.user` are ignored. Every access is a plain read or write.
- Response: every grant yields `p_valid[p]=1` exactly one cycle later, with one pulse per grant.
  - Read: `p.data` = bank word as it was before any write in the grant cycle. Same-cycle read and write to one bank cannot occur because of arbitration.
  - Write: `p.data` = 0.
  - When `p_valid=0`, `p.data` = 0.
- Ungranted requestors must hold the request. The block keeps no request state across cycles except `rr_q`.
- `conflict_cnt_o` increments by the number of ports with `q_valid=1 && q_ready=0` in each cycle. It saturates at 0xFFFF_FFFF and resets to 0.

## Timing
- Reset values: all `q_ready`=0, `p_valid`=0, `p.data`=0, `conflict_cnt_o`=0, memory=0.
- `q_ready` is combinational from same-cycle `q_valid` and `q.addr`. It has no dependence on `p` signals.
- Read latency: grant at cycle t, data valid at cycle t+1.
- Write visibility: a read granted at t+1 sees a write granted at t.
- Throughput: one access per bank per cycle. With no conflicts, all `NumPorts` ports are served every cycle.
- Backpressure: none on the response side. `p_valid` is not held and there is no `p_ready`.
- Reset asserted mid-operation:
  - Responses due next cycle are dropped.
  - `p_valid` goes low immediately (asynchronously).
  - Memory and `rr_q` are cleared.

## Test plan
- Write then read, conflict-free: ports 0..15 write to byte addresses 0x000, 0x008, …, 0x078 with data 0x1000+i and strb 0xFF. All `q_ready`=1 that cycle; 16 `p_valid` pulses with data 0 next cycle. A read burst to the same addresses two cycles later returns 0x1000+i on port i one cycle after grant. `conflict_cnt_o` = 0.
- Bank conflict: ports 0, 5 and 9 all read addr 0x100 (bank 0) and hold `q_valid`. Grants go to 0, 5, 9 on consecutive cycles. `conflict_cnt_o` ends at 3 (2 after the first cycle, +1 after the second).
- Round-robin fairness: ports 2 and 3 continuously request bank 4. Grants alternate 2, 3, 2, 3, starting with 2 from reset.
- Byte strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x040, then write 0x0000_0000_0000_00AB with strb 0x01. A read of 0x040 returns 0xFFFF_FFFF_FFFF_FFAB.
- Aliasing: write 0xDEAD to 0x4008, then read 0x0008. The read returns 0xDEAD.
- Reset mid-read: a read is granted at t and `rst_ni` falls before the edge at t+1. `p_valid` stays 0, and a subsequent read of the same address returns 0.
